// File: rtl/mem_stage.sv
// MEM pipeline stage: runs load/store accesses over a req/ack data bus, aligns
// load data, flags misaligned accesses and drives the MEM/WB register.
module mem_stage #(
  parameter int EXP_W           = 4,
  parameter int EXP_LD_MISALIGN = 4,
  parameter int EXP_ST_MISALIGN = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_en,
  input  logic [EXP_W-1:0] ex_exp_code,
  input  logic [31:0]      ex_pc,
  input  logic [3:0]       ex_mem_op,
  input  logic [31:0]      ex_mem_wr_data,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_gpr_we_,
  input  logic [31:0]      ex_out,
  output logic             bus_req,
  output logic             bus_we,
  output logic [29:0]      bus_addr,
  output logic [3:0]       bus_be,
  output logic [31:0]      bus_wr_data,
  input  logic [31:0]      bus_rd_data,
  input  logic             bus_ack,
  output logic             busy,
  output logic             mem_en,
  output logic [EXP_W-1:0] mem_exp_code,
  output logic [31:0]      mem_pc,
  output logic [4:0]       mem_rd_addr,
  output logic             mem_gpr_we_,
  output logic [31:0]      mem_out,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [EXP_W-1:0] LD_MIS = EXP_W'(EXP_LD_MISALIGN);
  localparam logic [EXP_W-1:0] ST_MIS = EXP_W'(EXP_ST_MISALIGN);

  state_t state_q, state_d;

  // Decode of the instruction currently in EX/MEM
  logic        is_load, is_store, aligned, ldst_ok, access, misalign, start;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  // Access context captured when the bus transaction starts
  logic [3:0]  op_q;
  logic [1:0]  lo_q;
  logic [31:0] pc_q;
  logic [4:0]  rd_q;
  logic        gpr_we_q;
  logic [31:0] out_q;
  logic        abort_q;
  logic [31:0] buf_data;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] acc_data;
  logic        acc_is_store;
  logic        aborted;

  always_comb begin
    is_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
    is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
    aligned  = 1'b1;
    case (ex_mem_op)
      OP_LH, OP_LHU, OP_SH: aligned = ~ex_out[0];
      OP_LW, OP_SW:         aligned = (ex_out[1:0] == 2'b00);
      default:              aligned = 1'b1;
    endcase
    ldst_ok  = ex_en && (ex_exp_code == '0) && (is_load || is_store);
    access   = ldst_ok && aligned;
    misalign = ldst_ok && !aligned;
    start    = (state_q == S_IDLE) && access && !stall && !flush;
  end

  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    case (ex_mem_op)
      OP_SB: begin
        st_be   = 4'b0001 << ex_out[1:0];
        st_data = {4{ex_mem_wr_data[7:0]}};
      end
      OP_SH: begin
        st_be   = ex_out[1] ? 4'b1100 : 4'b0011;
        st_data = {2{ex_mem_wr_data[15:0]}};
      end
      OP_SW: begin
        st_be   = 4'b1111;
        st_data = ex_mem_wr_data;
      end
      default: begin
        st_be   = 4'b1111;
        st_data = 32'h0;
      end
    endcase
    if (ex_mem_op == OP_LB || ex_mem_op == OP_LBU) st_be = 4'b0001 << ex_out[1:0];
    if (ex_mem_op == OP_LH || ex_mem_op == OP_LHU) st_be = ex_out[1] ? 4'b1100 : 4'b0011;
  end

  always_comb begin
    ld_byte = 8'h00;
    case (lo_q)
      2'd0: ld_byte = bus_rd_data[7:0];
      2'd1: ld_byte = bus_rd_data[15:8];
      2'd2: ld_byte = bus_rd_data[23:16];
      2'd3: ld_byte = bus_rd_data[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = lo_q[1] ? bus_rd_data[31:16] : bus_rd_data[15:0];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = bus_rd_data;
    endcase
    acc_is_store = (op_q >= OP_SB);
    acc_data     = acc_is_store ? out_q : ld_data;
    aborted      = abort_q || flush;
  end

  // Bus handshake: bus_req is high for every cycle in WAIT and the other bus_*
  // outputs stay frozen until the cycle where bus_ack=1 completes the transfer;
  // req is never withdrawn before ack, even when the access has been flushed.
  assign bus_req   = (state_q == S_WAIT);
  assign busy      = ((state_q == S_IDLE) && access && !flush) ||
                     ((state_q == S_WAIT) && !bus_ack);
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WAIT;
      S_WAIT:  if (bus_ack) state_d = stall ? S_DONE : S_IDLE;
      S_DONE:  if (!stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_we      <= 1'b0;
      bus_addr    <= 30'h0;
      bus_be      <= 4'h0;
      bus_wr_data <= 32'h0;
      op_q        <= 4'h0;
      lo_q        <= 2'b00;
      pc_q        <= 32'h0;
      rd_q        <= 5'h0;
      gpr_we_q    <= 1'b1;
      out_q       <= 32'h0;
      abort_q     <= 1'b0;
      buf_data    <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bus_we      <= is_store;
            bus_addr    <= ex_out[31:2];
            bus_be      <= st_be;
            bus_wr_data <= st_data;
            op_q        <= ex_mem_op;
            lo_q        <= ex_out[1:0];
            pc_q        <= ex_pc;
            rd_q        <= ex_rd_addr;
            gpr_we_q    <= ex_gpr_we_;
            out_q       <= ex_out;
            abort_q     <= 1'b0;
          end
        end
        S_WAIT: begin
          abort_q <= aborted;
          if (bus_ack) begin
            buf_data    <= acc_data;
            bus_we      <= 1'b0;
            bus_addr    <= 30'h0;
            bus_be      <= 4'h0;
            bus_wr_data <= 32'h0;
          end
        end
        S_DONE:  abort_q <= aborted;
        default: abort_q <= 1'b0;
      endcase
    end
  end

  // MEM/WB register; stall takes priority over flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_en       <= 1'b0;
      mem_exp_code <= '0;
      mem_pc       <= 32'h0;
      mem_rd_addr  <= 5'h0;
      mem_gpr_we_  <= 1'b1;
      mem_out      <= 32'h0;
    end else if (!stall) begin
      mem_en       <= 1'b0;
      mem_exp_code <= '0;
      mem_pc       <= 32'h0;
      mem_rd_addr  <= 5'h0;
      mem_gpr_we_  <= 1'b1;
      mem_out      <= 32'h0;
      case (state_q)
        S_IDLE: begin
          if (!flush && !access) begin
            mem_en       <= ex_en;
            mem_exp_code <= misalign ? (is_load ? LD_MIS : ST_MIS) : ex_exp_code;
            mem_pc       <= ex_pc;
            mem_rd_addr  <= ex_rd_addr;
            mem_gpr_we_  <= misalign ? 1'b1 : ex_gpr_we_;
            mem_out      <= ex_out;
          end
        end
        S_WAIT: begin
          if (bus_ack && !aborted) begin
            mem_en      <= 1'b1;
            mem_pc      <= pc_q;
            mem_rd_addr <= rd_q;
            mem_gpr_we_ <= acc_is_store ? 1'b1 : gpr_we_q;
            mem_out     <= acc_data;
          end
        end
        S_DONE: begin
          if (!aborted) begin
            mem_en      <= 1'b1;
            mem_pc      <= pc_q;
            mem_rd_addr <= rd_q;
            mem_gpr_we_ <= acc_is_store ? 1'b1 : gpr_we_q;
            mem_out     <= buf_data;
          end
        end
        default: mem_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-instruction vectors plus
// hand-written sequences for wait states, flush, reset and stall corners.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, ex_en, ex_gpr_we_;
  logic [3:0]  ex_exp_code, ex_mem_op;
  logic [31:0] ex_pc, ex_mem_wr_data, ex_out;
  logic [4:0]  ex_rd_addr;
  logic        bus_req, bus_we, bus_ack, busy;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic        mem_en, mem_gpr_we_;
  logic [3:0]  mem_exp_code;
  logic [31:0] mem_pc, mem_out;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  mem_stage #(.EXP_W(4), .EXP_LD_MISALIGN(4), .EXP_ST_MISALIGN(6)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_en(ex_en), .ex_exp_code(ex_exp_code), .ex_pc(ex_pc), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_rd_addr(ex_rd_addr), .ex_gpr_we_(ex_gpr_we_),
    .ex_out(ex_out), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_ack(bus_ack), .busy(busy), .mem_en(mem_en), .mem_exp_code(mem_exp_code),
    .mem_pc(mem_pc), .mem_rd_addr(mem_rd_addr), .mem_gpr_we_(mem_gpr_we_),
    .mem_out(mem_out), .state_dbg(state_dbg)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  xcode;
    logic        we_in;
    logic        acc;
    logic [3:0]  be;
    logic [31:0] bus_wd;
    logic [3:0]  code;
    logic        we_out;
    logic [31:0] out;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];
  logic [31:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [3:0] xcode, input logic we_in, input logic acc,
                              input logic [3:0] be, input logic [31:0] bus_wd,
                              input logic [3:0] code, input logic we_out, input logic [31:0] out);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.xcode = xcode; v.we_in = we_in; v.acc = acc; v.be = be; v.bus_wd = bus_wd;
    v.code = code; v.we_out = we_out; v.out = out;
    return v;
  endfunction

  task automatic mem_bubble_chk(input string name);
    chk({name, ".mem_en"}, 32'(mem_en), 32'd0);
    chk({name, ".mem_gpr_we_"}, 32'(mem_gpr_we_), 32'd1);
    chk({name, ".mem_out"}, mem_out, 32'h0);
    chk({name, ".mem_pc"}, mem_pc, 32'h0);
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] rd, input logic we_);
    ex_en = 1'b1; ex_exp_code = 4'd0; ex_mem_op = op; ex_out = addr;
    ex_mem_wr_data = wd; ex_pc = pc; ex_rd_addr = rd; ex_gpr_we_ = we_;
  endtask

  initial begin
    //          name      op  addr          wdata         rdata         xc we acc be      bus_wd        code we_o out
    vt[0]  = mk("lw",     5, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 1, 4'hF, 32'h0,        0, 0, 32'hDEADBEEF);
    vt[1]  = mk("lb",     1, 32'h103, 32'h0,        32'h80123456, 0, 0, 1, 4'h8, 32'h0,        0, 0, 32'hFFFFFF80);
    vt[2]  = mk("lbu",    2, 32'h103, 32'h0,        32'h80123456, 0, 0, 1, 4'h8, 32'h0,        0, 0, 32'h00000080);
    vt[3]  = mk("lh",     3, 32'h102, 32'h0,        32'h80017FFF, 0, 0, 1, 4'hC, 32'h0,        0, 0, 32'hFFFF8001);
    vt[4]  = mk("lhu",    4, 32'h100, 32'h0,        32'h1234F00F, 0, 0, 1, 4'h3, 32'h0,        0, 0, 32'h0000F00F);
    vt[5]  = mk("lb1",    1, 32'h101, 32'h0,        32'h00007F00, 0, 0, 1, 4'h2, 32'h0,        0, 0, 32'h0000007F);
    vt[6]  = mk("lh0",    3, 32'h100, 32'h0,        32'hFFFF8000, 0, 0, 1, 4'h3, 32'h0,        0, 0, 32'hFFFF8000);
    vt[7]  = mk("sb",     6, 32'h201, 32'h000000A5, 32'h0,        0, 0, 1, 4'h2, 32'hA5A5A5A5, 0, 1, 32'h201);
    vt[8]  = mk("sw",     8, 32'h300, 32'hCAFEF00D, 32'h0,        0, 0, 1, 4'hF, 32'hCAFEF00D, 0, 1, 32'h300);
    vt[9]  = mk("lw_mis", 5, 32'h101, 32'h0,        32'h0,        0, 0, 0, 4'h0, 32'h0,        4, 1, 32'h101);
    vt[10] = mk("sw_mis", 8, 32'h102, 32'h11111111, 32'h0,        0, 0, 0, 4'h0, 32'h0,        6, 1, 32'h102);
    vt[11] = mk("lhumis", 4, 32'h103, 32'h0,        32'h0,        0, 0, 0, 4'h0, 32'h0,        4, 1, 32'h103);
    vt[12] = mk("nop",    0, 32'h55AA,32'h0,        32'h0,        0, 0, 0, 4'h0, 32'h0,        0, 0, 32'h55AA);
    vt[13] = mk("op15",  15, 32'h1234,32'h0,        32'h0,        0, 1, 0, 4'h0, 32'h0,        0, 1, 32'h1234);
    vt[14] = mk("lw_exc", 5, 32'h100, 32'h0,        32'h0,        2, 0, 0, 4'h0, 32'h0,        2, 0, 32'h100);

    reset = 1'b0; stall = 1'b0; flush = 1'b0; ex_en = 1'b0; ex_exp_code = 4'd0;
    ex_pc = 32'h0; ex_mem_op = 4'd0; ex_mem_wr_data = 32'h0; ex_rd_addr = 5'd0;
    ex_gpr_we_ = 1'b1; ex_out = 32'h0; bus_rd_data = 32'h0; bus_ack = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst.bus_req", 32'(bus_req), 32'd0);
    chk("rst.bus_be", 32'(bus_be), 32'd0);
    chk("rst.state", 32'(state_dbg), 32'd0);
    mem_bubble_chk("rst");
    reset = 1'b1;
    tick();

    // Single-instruction vectors
    for (int i = 0; i < NV; i++) begin
      present(vt[i].op, vt[i].addr, vt[i].wdata, 32'h1000 + 32'(i) * 32'd4, 5'(i + 1), vt[i].we_in);
      ex_exp_code = vt[i].xcode;
      exp_q.push_back(vt[i].out);
      #1 chk({vt[i].name, ".busy"}, 32'(busy), 32'(vt[i].acc));
      tick();
      if (vt[i].acc) begin
        chk({vt[i].name, ".bus_req"}, 32'(bus_req), 32'd1);
        chk({vt[i].name, ".bus_we"}, 32'(bus_we), 32'(vt[i].op >= 4'd6));
        chk({vt[i].name, ".bus_addr"}, 32'(bus_addr), vt[i].addr >> 2);
        chk({vt[i].name, ".bus_be"}, 32'(bus_be), 32'(vt[i].be));
        if (vt[i].op >= 4'd6) chk({vt[i].name, ".bus_wr_data"}, bus_wr_data, vt[i].bus_wd);
        bus_ack = 1'b1; bus_rd_data = vt[i].rdata;
        #1 chk({vt[i].name, ".busy_ack"}, 32'(busy), 32'd0);
        tick();
        bus_ack = 1'b0; bus_rd_data = 32'h0;
      end else begin
        chk({vt[i].name, ".no_req"}, 32'(bus_req), 32'd0);
      end
      ex_en = 1'b0;
      chk({vt[i].name, ".mem_en"}, 32'(mem_en), 32'd1);
      chk({vt[i].name, ".mem_pc"}, mem_pc, 32'h1000 + 32'(i) * 32'd4);
      chk({vt[i].name, ".mem_rd"}, 32'(mem_rd_addr), 32'(i + 1));
      chk({vt[i].name, ".mem_exp"}, 32'(mem_exp_code), 32'(vt[i].code));
      chk({vt[i].name, ".mem_we_"}, 32'(mem_gpr_we_), 32'(vt[i].we_out));
      chk({vt[i].name, ".mem_out"}, mem_out, exp_q.pop_front());
      chk({vt[i].name, ".bus_req_after"}, 32'(bus_req), 32'd0);
      tick();
    end

    // SH with three wait cycles: busy and bus_* stable throughout
    present(4'd7, 32'h202, 32'h1234ABCD, 32'h2000, 5'd3, 1'b0);
    tick();
    for (int w = 0; w < 3; w++) begin
      #1;
      chk("sh.busy", 32'(busy), 32'd1);
      chk("sh.req", 32'(bus_req), 32'd1);
      chk("sh.we", 32'(bus_we), 32'd1);
      chk("sh.addr", 32'(bus_addr), 32'h80);
      chk("sh.be", 32'(bus_be), 32'hC);
      chk("sh.wd", bus_wr_data, 32'hABCDABCD);
      tick();
    end
    bus_ack = 1'b1;
    #1 chk("sh.busy_ack", 32'(busy), 32'd0);
    tick();
    bus_ack = 1'b0; ex_en = 1'b0;
    chk("sh.mem_en", 32'(mem_en), 32'd1);
    chk("sh.mem_out", mem_out, 32'h202);
    chk("sh.mem_we_", 32'(mem_gpr_we_), 32'd1);
    chk("sh.req_off", 32'(bus_req), 32'd0);
    tick();

    // Flush during WAIT: req held to ack, result becomes a bubble
    present(4'd5, 32'h100, 32'h0, 32'h3000, 5'd4, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl.req_held", 32'(bus_req), 32'd1);
    tick();
    chk("fl.req_held2", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_rd_data = 32'hDEADBEEF;
    tick();
    bus_ack = 1'b0; ex_en = 1'b0;
    chk("fl.req_off", 32'(bus_req), 32'd0);
    mem_bubble_chk("fl");
    tick();

    // Flush in IDLE: access suppressed, bubble loaded
    present(4'd0, 32'h99, 32'h0, 32'h3100, 5'd5, 1'b0);
    tick();
    chk("fi.pre_en", 32'(mem_en), 32'd1);
    present(4'd5, 32'h104, 32'h0, 32'h3104, 5'd6, 1'b0);
    flush = 1'b1;
    #1 chk("fi.busy", 32'(busy), 32'd0);
    tick();
    flush = 1'b0; ex_en = 1'b0;
    chk("fi.no_req", 32'(bus_req), 32'd0);
    chk("fi.state", 32'(state_dbg), 32'd0);
    mem_bubble_chk("fi");

    // Stall with nothing pending: MEM/WB holds
    present(4'd0, 32'h77, 32'h0, 32'h500, 5'd7, 1'b0);
    tick();
    chk("sn.out", mem_out, 32'h77);
    stall = 1'b1;
    present(4'd0, 32'h88, 32'h0, 32'h504, 5'd8, 1'b0);
    tick();
    chk("sn.hold_out", mem_out, 32'h77);
    chk("sn.hold_pc", mem_pc, 32'h500);
    stall = 1'b0; ex_en = 1'b0;
    tick();

    // Stall on the ack cycle for two cycles: DONE, then load on release
    present(4'd5, 32'h104, 32'h0, 32'h600, 5'd9, 1'b0);
    tick();
    bus_ack = 1'b1; bus_rd_data = 32'h11223344; stall = 1'b1;
    tick();
    bus_ack = 1'b0; bus_rd_data = 32'h0; ex_en = 1'b0;
    chk("st.state1", 32'(state_dbg), 32'd2);
    chk("st.busy1", 32'(busy), 32'd0);
    chk("st.req1", 32'(bus_req), 32'd0);
    mem_bubble_chk("st1");
    tick();
    chk("st.state2", 32'(state_dbg), 32'd2);
    mem_bubble_chk("st2");
    stall = 1'b0;
    tick();
    chk("st.mem_en", 32'(mem_en), 32'd1);
    chk("st.mem_out", mem_out, 32'h11223344);
    chk("st.mem_pc", mem_pc, 32'h600);
    chk("st.mem_we_", 32'(mem_gpr_we_), 32'd0);
    chk("st.state3", 32'(state_dbg), 32'd0);
    tick();

    // Reset during WAIT abandons the store
    present(4'd8, 32'h300, 32'hCAFEF00D, 32'h700, 5'd10, 1'b0);
    tick();
    chk("rw.req", 32'(bus_req), 32'd1);
    chk("rw.we", 32'(bus_we), 32'd1);
    reset = 1'b0;
    tick();
    chk("rw.req_off", 32'(bus_req), 32'd0);
    chk("rw.we_off", 32'(bus_we), 32'd0);
    chk("rw.addr", 32'(bus_addr), 32'd0);
    chk("rw.be", 32'(bus_be), 32'd0);
    chk("rw.wd", bus_wr_data, 32'd0);
    chk("rw.state", 32'(state_dbg), 32'd0);
    mem_bubble_chk("rw");
    reset = 1'b1; ex_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage that sits directly downstream of the EX/MEM register and consumes its outputs.
- Runs load/store accesses on the data bus through a req/ack handshake.
- Aligns and extends load data, and detects misaligned accesses.
- Drives the MEM/WB pipeline register. Asserts `busy` so pipeline control can stall upstream stages while a bus access is outstanding.

Parameters:
- EXP_W, 4: exception code width.
- EXP_LD_MISALIGN, 4: code raised for a misaligned load.
- EXP_ST_MISALIGN, 6: code raised for a misaligned store.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- stall  in  1  pipeline stall from control; holds the MEM/WB register
- flush  in  1  pipeline flush; turns this stage's result into a bubble
- ex_en  in  1  valid instruction in EX/MEM
- ex_exp_code  in  EXP_W  incoming exception; 0 = none
- ex_pc  in  32  instruction PC
- ex_mem_op  in  4  0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NOP
- ex_mem_wr_data  in  32  store data
- ex_rd_addr  in  5  destination register
- ex_gpr_we_  in  1  active-low register write enable
- ex_out  in  32  ALU result; this is the byte address for memory ops
- bus_req  out  1  access request
- bus_we  out  1  1 = write
- bus_addr  out  30  word address (ex_out[31:2])
- bus_be  out  4  byte enables, little-endian
- bus_wr_data  out  32  lane-replicated store data
- bus_rd_data  in  32  read data, valid when bus_ack=1
- bus_ack  in  1  access complete
- busy  out  1  stage cannot accept a new instruction this cycle
- mem_en  out  1  MEM/WB valid
- mem_exp_code  out  EXP_W  MEM/WB exception code
- mem_pc  out  32  MEM/WB PC
- mem_rd_addr  out  5  MEM/WB destination register
- mem_gpr_we_  out  1  MEM/WB active-low write enable
- mem_out  out  32  MEM/WB result

Behaviour:
- Reset (reset==0 at a clk edge):
  - State = IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wr_data=0.
  - mem_en=0, mem_exp_code=0, mem_pc=0, mem_rd_addr=0, mem_gpr_we_=1, mem_out=0.
  - Reset mid-access abandons the transaction; bus_req is low from the next cycle.
- "Access" condition (all must hold):
  - ex_en=1,
  - ex_exp_code=0,
  - mem_op is a load or store,
  - address is aligned: LH/LHU/SH need ex_out[0]=0; LW/SW need ex_out[1:0]=0.
- Misaligned ld/st with ex_en=1 and ex_exp_code=0:
  - No bus access.
  - Result: exp_code = EXP_LD_MISALIGN or EXP_ST_MISALIGN, gpr_we_=1, out=ex_out.
- Non-access instructions pass through with 1-cycle latency, exactly like a register.
  - mem_out = ex_out; all other fields copied.
- FSM states IDLE, WAIT, DONE:
  - IDLE: if Access, stall=0 and flush=0, go to WAIT on the next edge and register the bus_* outputs.
  - WAIT: bus_req=1, with all bus_* outputs held stable until bus_ack. On bus_ack:
    - if stall=0, load MEM/WB and go to IDLE;
    - if stall=1, latch the result into an internal buffer and go to DONE.
  - DONE: when stall=0, load MEM/WB from the buffer and go to IDLE.
- busy (combinational) = (IDLE & Access & flush=0) | (WAIT & !bus_ack). busy=0 in DONE.
- A 1-cycle-ack load presented at edge N appears on mem_out after edge N+2.
- Load data:
  - Byte lane selected by addr[1:0], halfword lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Store data:
  - SB: be = 1<<addr[1:0], data = byte replicated x4.
  - SH: be = 4'b0011 or 4'b1100 by addr[1], data = half replicated x2.
  - SW: be = 4'b1111.
  - Store result: mem_gpr_we_=1, mem_out=ex_out.
- flush in IDLE: MEM/WB loads a bubble (en=0, exp_code=0, pc=0, rd=0, gpr_we_=1, out=0); no access starts.
- flush in WAIT/DONE:
  - The access is marked aborted and the bus transaction still runs to ack (bus_req is never dropped early).
  - busy follows the normal rule.
  - The result is replaced by a bubble.
  - A store already issued still completes.
- stall=1 with no access pending: MEM/WB holds its value.
- stall has priority over flush for the MEM/WB register, matching the EX/MEM register.

Test Plan:
- LW aligned:
  - Stimulus: ex_out=0x100, bus_rd_data=0xDEADBEEF, ack 1 cycle after req.
  - Response: busy=1 for 1 cycle, bus_be=4'hF, bus_addr=0x40; mem_out=0xDEADBEEF with mem_gpr_we_=0 two edges after presentation.
- LB/LBU:
  - Stimulus: addr=0x103, rd_data=0x80xxxxxx.
  - Response: LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH:
  - Stimulus: addr=0x202, wr_data=0x1234ABCD.
  - Response: bus_we=1, bus_be=4'b1100, bus_wr_data=0xABCDABCD; ack after 3 wait cycles keeps busy=1 and bus_* stable throughout.
- Misaligned:
  - Stimulus: LW at 0x101.
  - Response: no bus_req, mem_exp_code=4; SW at 0x102 gives 6; mem_out equals the address in both cases.
- Flush during WAIT:
  - Response: bus_req stays high until ack, then mem_en=0 and mem_gpr_we_=1.
  - Reset (reset=0) during WAIT: bus_req=0 and all outputs at reset values after one edge.
- Stall at ack:
  - Stimulus: stall=1 on the ack cycle for 2 cycles.
  - Response: state DONE, MEM/WB unchanged, busy=0; loaded on the first stall=0 edge, then IDLE.
